// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_reader
// Brief    : 640x480@60 VGA timing plus a centred RGB332 framebuffer reader.
//            Sync, blank and colour are delay-matched to the memory read latency.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int IMG_X0   = 192,
    parameter int IMG_Y0   = 112,
    parameter int READ_LAT = 2,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] read_address,
    input  logic [7:0]        pixel_value,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_SHIFT   = $clog2(IMG_W);

    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_START = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_HW-1:0] c_IMG_X0   = c_HW'(IMG_X0);
    localparam logic [c_HW-1:0] c_IMG_X1   = c_HW'(IMG_X0 + IMG_W);

    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_START = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_VW-1:0] c_IMG_Y0   = c_VW'(IMG_Y0);
    localparam logic [c_VW-1:0] c_IMG_Y1   = c_VW'(IMG_Y0 + IMG_H);

    logic [c_HW-1:0]   r_h_cnt;
    logic [c_VW-1:0]   r_v_cnt;

    logic              w_hs;
    logic              w_vs;
    logic              w_vis;
    logic              w_img;
    logic              w_fs;
    logic [ADDR_W-1:0] w_hrel;
    logic [ADDR_W-1:0] w_vrel;
    logic [ADDR_W-1:0] w_addr;

    logic [READ_LAT:0] r_hs_pipe;
    logic [READ_LAT:0] r_vs_pipe;
    logic [READ_LAT:0] r_vis_pipe;
    logic [READ_LAT:0] r_img_pipe;
    logic [READ_LAT:0] r_fs_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    always_comb begin
        w_hs   = !((r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END));
        w_vs   = !((r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END));
        w_vis  = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
        w_img  = w_vis && (r_h_cnt >= c_IMG_X0) && (r_h_cnt < c_IMG_X1)
                       && (r_v_cnt >= c_IMG_Y0) && (r_v_cnt < c_IMG_Y1);
        w_fs   = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_hrel = ADDR_W'(r_h_cnt) - ADDR_W'(IMG_X0);
        w_vrel = ADDR_W'(r_v_cnt) - ADDR_W'(IMG_Y0);
        // IMG_W is a power of two, so the row stride is a plain shift.
        w_addr = (w_vrel << c_SHIFT) + w_hrel;
    end

    // Address register plus READ_LAT+1 control stages: the last stage lines
    // up with the cycle in which pixel_value holds the matching byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_address <= '0;
            r_hs_pipe    <= '1;
            r_vs_pipe    <= '1;
            r_vis_pipe   <= '0;
            r_img_pipe   <= '0;
            r_fs_pipe    <= '0;
        end else begin
            read_address <= w_img ? w_addr : '0;
            r_hs_pipe    <= {r_hs_pipe[READ_LAT-1:0],  w_hs};
            r_vs_pipe    <= {r_vs_pipe[READ_LAT-1:0],  w_vs};
            r_vis_pipe   <= {r_vis_pipe[READ_LAT-1:0], w_vis};
            r_img_pipe   <= {r_img_pipe[READ_LAT-1:0], w_img};
            r_fs_pipe    <= {r_fs_pipe[READ_LAT-1:0],  w_fs};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            vga_hsync   <= r_hs_pipe[READ_LAT];
            vga_vsync   <= r_vs_pipe[READ_LAT];
            vga_blank_n <= r_vis_pipe[READ_LAT];
            frame_start <= r_fs_pipe[READ_LAT];
            if (r_img_pipe[READ_LAT]) begin
                vga_r <= {pixel_value[7:5], pixel_value[7:5], pixel_value[7:6]};
                vga_g <= {pixel_value[4:2], pixel_value[4:2], pixel_value[4:3]};
                vga_b <= {pixel_value[1:0], pixel_value[1:0],
                          pixel_value[1:0], pixel_value[1:0]};
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

    assign vga_sync_n = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vga_frame_reader
// Brief    : Scaled-geometry bench for vga_frame_reader with a random framebuffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_reader;

    // Reduced screen geometry keeps whole frames short; rules are unchanged.
    localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACTIVE = 48, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int IMG_W = 32, IMG_H = 16, IMG_X0 = 16, IMG_Y0 = 20;
    localparam int READ_LAT = 2, ADDR_W = 16;
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int LAT   = READ_LAT + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] read_address;
    logic [7:0]        pixel_value;
    logic              vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start;
    logic [7:0]        vga_r, vga_g, vga_b;

    vga_frame_reader #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0),
        .READ_LAT(READ_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .read_address(read_address),
        .pixel_value(pixel_value), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
    );

    always #20 clk = ~clk;

    logic [7:0] mem [0:65535];
    logic [7:0] rd_q [0:READ_LAT-1];

    always @(posedge clk) begin
        rd_q[0] <= mem[read_address];
        for (int i = 1; i < READ_LAT; i++) rd_q[i] <= rd_q[i-1];
    end
    assign pixel_value = rd_q[READ_LAT-1];

    int k = 0;
    bit armed = 1'b0;
    always @(posedge clk) begin
        armed <= 1'b1;
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    typedef struct packed {
        logic              hs;
        logic              vs;
        logic              blank_n;
        logic              fs;
        logic              img;
        logic [ADDR_W-1:0] addr;
    } pos_t;

    function automatic pos_t model(input int p);
        pos_t e;
        int h, v;
        h = p % H_TOT;
        v = (p / H_TOT) % V_TOT;
        e.hs      = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
        e.vs      = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
        e.blank_n = (h < H_ACTIVE) && (v < V_ACTIVE);
        e.fs      = (h == 0) && (v == 0);
        e.img     = e.blank_n && h >= IMG_X0 && h < IMG_X0 + IMG_W
                              && v >= IMG_Y0 && v < IMG_Y0 + IMG_H;
        e.addr    = e.img ? ADDR_W'((v - IMG_Y0) * IMG_W + (h - IMG_X0)) : '0;
        return e;
    endfunction

    // 3/3/2-bit channels scaled to 8 bits by bit replication.
    function automatic logic [23:0] expand(input logic [7:0] b);
        int r3, g3, b2, r, g, bl;
        r3 = int'(b) / 32;
        g3 = (int'(b) / 4) % 8;
        b2 = int'(b) % 4;
        r  = r3 * 36 + r3 / 2;
        g  = g3 * 36 + g3 / 2;
        bl = b2 * 85;
        return {r[7:0], g[7:0], bl[7:0]};
    endfunction

    int fs_last = 0, fs_seg = 0, hrun = 0, vrun = 0;
    bit fs_seen = 1'b0;

    always @(negedge clk) begin : cmp
        pos_t        e, ea;
        logic [23:0] rgb_e, rgb_a;
        int          hp, vp, ha, va;
        if (armed) begin
            rgb_a = {vga_r, vga_g, vga_b};
            if (k < LAT) begin
                e = '0;
                e.hs = 1'b1;
                e.vs = 1'b1;
                rgb_e = '0;
            end else begin
                e = model(k - LAT);
                rgb_e = e.img ? expand(mem[e.addr]) : 24'h0;
            end
            ea = (k >= 1) ? model(k - 1) : pos_t'(0);
            chk("hsync",   vga_hsync,   e.hs);
            chk("vsync",   vga_vsync,   e.vs);
            chk("blank_n", vga_blank_n, e.blank_n);
            chk("fstart",  frame_start, e.fs);
            chk("rgb",     rgb_a,       rgb_e);
            chk("sync_n",  vga_sync_n,  1'b0);
            chk("raddr",   read_address, ea.addr);

            if (k >= 1) begin
                ha = (k - 1) % H_TOT;
                va = ((k - 1) / H_TOT) % V_TOT;
                if (ha == 16 && va == 20) chk("addr_origin", read_address, 0);
                if (ha == 21 && va == 22) chk("addr_21_22",  read_address, 69);
                if (ha == 47 && va == 35) chk("addr_last",   read_address, 511);
                if (ha == 10 && va == 5)  chk("addr_border", read_address, 0);
            end
            if (k >= LAT) begin
                hp = (k - LAT) % H_TOT;
                vp = ((k - LAT) / H_TOT) % V_TOT;
                if (hp == 21 && vp == 22) chk("rgb_E3",      rgb_a, 24'hFF00FF);
                if (hp == 22 && vp == 22) chk("rgb_1C",      rgb_a, 24'h00FF00);
                if (hp == 16 && vp == 20) chk("rgb_img_org", rgb_a, 24'hFFFFFF);
                if (hp == 0  && vp == 0)  chk("rgb_0_0",     rgb_a, 24'h0);
                if (hp == 15 && vp == 20) chk("rgb_left",    rgb_a, 24'h0);
                if (hp == 48 && vp == 30) chk("rgb_right",   rgb_a, 24'h0);
            end

            if (rst) begin
                fs_seen = 1'b0;
                fs_seg  = 0;
                hrun    = 0;
                vrun    = 0;
            end else begin
                if (frame_start) begin
                    if (!fs_seen) chk("fs_first",  k, LAT);
                    else          chk("fs_period", k - fs_last, FRAME);
                    fs_last = k;
                    fs_seen = 1'b1;
                    fs_seg++;
                end
                if (!vga_hsync) hrun++;
                else if (hrun != 0) begin
                    chk("hsync_width", hrun, H_SYNC);
                    hrun = 0;
                end
                if (!vga_vsync) vrun++;
                else if (vrun != 0) begin
                    chk("vsync_width", vrun, V_SYNC * H_TOT);
                    vrun = 0;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0]  = 8'hFF;
        mem[69] = 8'hE3;
        mem[70] = 8'h1C;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat ($urandom_range(1000, 3000)) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * FRAME + 200) @(posedge clk);
        #1;
        chk("fs_count", fs_seg, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
